// File: rtl/asynchronous_fifo_if.sv
// Handshake bundle between a FIFO and its producer/consumer.
// The master side drives requests and write data; the slave side
// (the FIFO) returns registered read data and the occupancy flags.
interface asynchronous_fifo_if #(
  parameter int width = 8
);
  logic             w_en;
  logic             r_en;
  logic [width-1:0] data_in;
  logic [width-1:0] data_out;
  logic             full;
  logic             empty;

  modport master (
    output w_en,
    output r_en,
    output data_in,
    input  data_out,
    input  full,
    input  empty
  );

  modport slave (
    input  w_en,
    input  r_en,
    input  data_in,
    output data_out,
    output full,
    output empty
  );
endinterface

// File: rtl/asynchronous_fifo.sv
// Single-clock FIFO with depth x width storage.
// Read and write pointers carry one extra wrap bit above the address
// bits, so equal pointers mean empty and pointers that differ only in
// the wrap bit mean full. Read data is registered and holds between pops.
module asynchronous_fifo #(
  parameter int depth = 8,
  parameter int width = 8
) (
  input  logic               clk,
  input  logic               rst,
  asynchronous_fifo_if.slave bus
);

  localparam int aw = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [aw:0] ptr_one = {{aw{1'b0}}, 1'b1};

  logic [width-1:0] mem [depth];
  logic [aw:0]      wr_ptr;
  logic [aw:0]      rd_ptr;
  logic [width-1:0] data_q;
  logic             full;
  logic             empty;
  logic             wr_accept;
  logic             rd_accept;

  // Occupancy flags and accept qualifiers come straight from the registered
  // pointers; a blocked request is simply not accepted, so full+read drops
  // the write and empty+write drops the read without any bypass path.
  always_comb begin
    empty     = (wr_ptr == rd_ptr);
    full      = (wr_ptr[aw] != rd_ptr[aw]) &&
                (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
    wr_accept = bus.w_en && !full;
    rd_accept = bus.r_en && !empty;
  end

  // Write pointer: advances once per accepted write, wrap bit toggles
  // naturally when the address bits roll over from depth-1 to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (wr_accept) begin
      wr_ptr <= wr_ptr + ptr_one;
    end
  end

  // Read pointer and registered output word; data_out only changes on a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      data_q <= '0;
    end else if (rd_accept) begin
      rd_ptr <= rd_ptr + ptr_one;
      data_q <= mem[rd_ptr[aw-1:0]];
    end
  end

  // Storage array is deliberately not reset; stale entries are unreachable
  // until the write pointer passes over them again.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr[aw-1:0]] <= bus.data_in;
    end
  end

  assign bus.data_out = data_q;
  assign bus.full     = full;
  assign bus.empty    = empty;

endmodule

// File: tb/tb_asynchronous_fifo.sv
// Directed bench for asynchronous_fifo (depth 8, width 8): reset, overfill,
// drain, pointer wrap, simultaneous access and mid-operation reset.
module tb_asynchronous_fifo;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  asynchronous_fifo_if #(.width(8)) bus ();

  asynchronous_fifo #(
    .depth(8),
    .width(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10 ns clock, rising edges at 5, 15, 25 ns ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive requests 1 ns after an edge, then wait for the next edge + 1 ns.
  task automatic apply_stimulus(input logic w, input logic r, input logic [7:0] d);
    bus.w_en    = w;
    bus.r_en    = r;
    bus.data_in = d;
    @(posedge clk);
    #1;
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
  endtask

  initial begin
    checks      = 0;
    fails       = 0;
    rst         = 1'b1;
    bus.w_en    = 1'b0;
    bus.r_en    = 1'b1;
    bus.data_in = 8'h00;

    // Reset held with a read request active
    #22;
    check_output("rst_data_out", {24'h0, bus.data_out}, 32'h0);
    check_output("rst_empty", {31'h0, bus.empty}, 32'h1);
    check_output("rst_full", {31'h0, bus.full}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_output("empty_read_data", {24'h0, bus.data_out}, 32'h0);
    check_output("empty_read_empty", {31'h0, bus.empty}, 32'h1);
    bus.r_en = 1'b0;

    // Overfill: 1..11, only 1..8 accepted
    for (int i = 1; i <= 11; i++) begin
      apply_stimulus(1'b1, 1'b0, 8'(i));
      check_output($sformatf("fill_full_%0d", i), {31'h0, bus.full},
                   (i >= 8) ? 32'h1 : 32'h0);
      check_output($sformatf("fill_empty_%0d", i), {31'h0, bus.empty}, 32'h0);
    end

    // Drain: 1..8 then hold 8
    for (int i = 1; i <= 11; i++) begin
      apply_stimulus(1'b0, 1'b1, 8'h00);
      check_output($sformatf("drain_data_%0d", i), {24'h0, bus.data_out},
                   (i <= 8) ? 32'(i) : 32'h8);
      check_output($sformatf("drain_empty_%0d", i), {31'h0, bus.empty},
                   (i >= 8) ? 32'h1 : 32'h0);
      check_output($sformatf("drain_full_%0d", i), {31'h0, bus.full}, 32'h0);
    end

    // Wrap: write 1..6, read 6, write 7..14, read all
    for (int i = 1; i <= 6; i++) apply_stimulus(1'b1, 1'b0, 8'(i));
    for (int i = 1; i <= 6; i++) begin
      apply_stimulus(1'b0, 1'b1, 8'h00);
      check_output($sformatf("wrap_rd_%0d", i), {24'h0, bus.data_out}, 32'(i));
    end
    for (int i = 7; i <= 14; i++) begin
      apply_stimulus(1'b1, 1'b0, 8'(i));
      check_output($sformatf("wrap_full_%0d", i), {31'h0, bus.full},
                   (i == 14) ? 32'h1 : 32'h0);
    end
    for (int i = 7; i <= 14; i++) begin
      apply_stimulus(1'b0, 1'b1, 8'h00);
      check_output($sformatf("wrap_rd_%0d", i), {24'h0, bus.data_out}, 32'(i));
    end
    check_output("wrap_empty", {31'h0, bus.empty}, 32'h1);

    // Simultaneous access at occupancy 4
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, 8'(8'h21 + i));
    for (int k = 0; k < 10; k++) begin
      apply_stimulus(1'b1, 1'b1, 8'(8'h25 + k));
      check_output($sformatf("sim_data_%0d", k), {24'h0, bus.data_out},
                   32'(8'h21 + k));
      check_output($sformatf("sim_empty_%0d", k), {31'h0, bus.empty}, 32'h0);
      check_output($sformatf("sim_full_%0d", k), {31'h0, bus.full}, 32'h0);
    end
    // Now holding 0x2B..0x2E; top up to full with 0x2F..0x32
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, 8'(8'h2F + i));
    check_output("sim_full_reached", {31'h0, bus.full}, 32'h1);
    apply_stimulus(1'b1, 1'b1, 8'hFF);
    check_output("full_both_data", {24'h0, bus.data_out}, 32'h2B);
    check_output("full_both_full", {31'h0, bus.full}, 32'h0);
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(1'b0, 1'b1, 8'h00);
      check_output($sformatf("post_full_rd_%0d", i), {24'h0, bus.data_out},
                   32'(8'h2C + i));
    end
    check_output("post_full_empty", {31'h0, bus.empty}, 32'h1);
    apply_stimulus(1'b1, 1'b1, 8'h55);
    check_output("empty_both_hold", {24'h0, bus.data_out}, 32'h32);
    check_output("empty_both_empty", {31'h0, bus.empty}, 32'h0);
    apply_stimulus(1'b0, 1'b1, 8'h00);
    check_output("empty_both_rd", {24'h0, bus.data_out}, 32'h55);
    check_output("empty_both_after", {31'h0, bus.empty}, 32'h1);

    // Mid-operation reset at occupancy 5
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 1'b0, 8'(8'h61 + i));
    apply_stimulus(1'b0, 1'b1, 8'h00);
    check_output("pre_rst_data", {24'h0, bus.data_out}, 32'h61);
    apply_stimulus(1'b1, 1'b0, 8'h66);
    #2;
    rst = 1'b1;
    #1;
    check_output("mid_rst_empty", {31'h0, bus.empty}, 32'h1);
    check_output("mid_rst_data", {24'h0, bus.data_out}, 32'h0);
    check_output("mid_rst_full", {31'h0, bus.full}, 32'h0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    apply_stimulus(1'b1, 1'b0, 8'hA5);
    check_output("after_rst_empty", {31'h0, bus.empty}, 32'h0);
    apply_stimulus(1'b0, 1'b1, 8'h00);
    check_output("after_rst_data", {24'h0, bus.data_out}, 32'hA5);
    check_output("after_rst_drained", {31'h0, bus.empty}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
